// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128 key schedule.
// Loads one 128-bit cipher key and streams round keys 0..NUM_ROUNDS, one per
// rk_valid/rk_ready handshake. Byte i of any 128-bit value sits at [8i+7:8i],
// word j at [32j+31:32j], row r of a word is byte r of that word.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   key_valid/key_ready cipher key handshake, key is the 128-bit cipher key
//   rk_valid/rk_ready   round key handshake, rk is the current round key
//   rk_index            round number of rk (0..NUM_ROUNDS)
//   rk_last             rk_valid && rk_index == NUM_ROUNDS

`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

// aes_sbox: forward AES S-box, one byte lane.
//   a_i  input byte
//   s_o  substituted byte
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  // Entry 0 is the leftmost byte of the literal, i.e. element 255; index by ~a_i.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign s_o = SBOX[~a_i];
endmodule

module aes_key_expander #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       key_valid,
  output logic                       key_ready,
  input  logic [`AES_BLOCK_SIZE-1:0] key,
  output logic                       rk_valid,
  input  logic                       rk_ready,
  output logic [127:0]               rk,
  output logic [3:0]                 rk_index,
  output logic                       rk_last
);
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  typedef enum logic {IDLE, RUN} state_e;

  state_e       state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   rcon_q, rcon_d;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // next(rk): RotWord moves byte 1 into byte 0, so w3 is rotated right by 8.
  logic [31:0] w3_rot, w3_sub, t;
  logic [31:0] n0, n1, n2, n3;

  assign w3_rot = {rk_q[103:96], rk_q[127:104]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_sbox u_sbox (
      .a_i(w3_rot[8*i +: 8]),
      .s_o(w3_sub[8*i +: 8])
    );
  end

  // Rcon lands in row 0, i.e. the low byte of the word.
  assign t  = w3_sub ^ {24'h0, rcon_q};
  assign n0 = rk_q[31:0]   ^ t;
  assign n1 = rk_q[63:32]  ^ n0;
  assign n2 = rk_q[95:64]  ^ n1;
  assign n3 = rk_q[127:96] ^ n2;

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          rk_d    = key;
          idx_d   = 4'd0;
          rcon_d  = 8'h01;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (idx_q == LAST) begin
            // rk and rk_index keep their final values while idle.
            state_d = IDLE;
          end else begin
            rk_d   = {n3, n2, n1, n0};
            idx_d  = idx_q + 4'd1;
            rcon_d = xtime(rcon_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rk_q    <= '0;
      idx_q   <= '0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
    end
  end

  assign key_ready = (state_q == IDLE);
  assign rk_valid  = (state_q == RUN);
  assign rk        = rk_q;
  assign rk_index  = idx_q;
  assign rk_last   = rk_valid && (idx_q == LAST);
endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander: a FIPS-197 style byte-matrix key
// schedule model (S-box derived from GF(2^8) inversion + affine map) fills a
// queue per DUT; negedge monitors pop and compare on every rk handshake.
module tb_aes_key_expander;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: full schedule
  logic         key_valid, key_ready, rk_valid, rk_ready, rk_last;
  logic [127:0] key, rk;
  logic [3:0]   rk_index;
  // DUT B: NUM_ROUNDS = 2
  logic         kv_b, kr_b, rv_b, rr_b, rl_b;
  logic [127:0] key_b, rk_b;
  logic [3:0]   ri_b;

  aes_key_expander #(.NUM_ROUNDS(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key(key), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk),
    .rk_index(rk_index), .rk_last(rk_last)
  );

  aes_key_expander #(.NUM_ROUNDS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_valid(kv_b), .key_ready(kr_b),
    .key(key_b), .rk_valid(rv_b), .rk_ready(rr_b), .rk(rk_b),
    .rk_index(ri_b), .rk_last(rl_b)
  );

  typedef struct packed {
    logic [127:0] rk;
    logic [3:0]   idx;
    logic         last;
  } exp_t;

  exp_t sb_a[$], sb_b[$];
  exp_t ea, eb;
  int checks = 0, errors = 0;
  int hs_a = 0, hs_b = 0;
  logic [127:0] cap_a [0:15];
  logic         last_a [0:15];
  logic [7:0]   sbt [0:255];
  logic [127:0] mdl [0:10];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (bound expired or unexpected event)", name);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] p, a;
    p = 8'h00;
    a = a_in;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbt[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 expansion over a 44x4 byte matrix.
  task automatic expand(input logic [127:0] k);
    logic [7:0] w [0:43][0:3];
    logic [7:0] tmp [0:3];
    logic [7:0] t0;
    logic [7:0] rc [0:9];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w[i][j] = k[8*(4*i+j) +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
      if (i % 4 == 0) begin
        t0     = tmp[0];
        tmp[0] = sbt[tmp[1]] ^ rc[i/4-1];
        tmp[1] = sbt[tmp[2]];
        tmp[2] = sbt[tmp[3]];
        tmp[3] = sbt[t0];
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
    end
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) mdl[r][8*(4*c+j) +: 8] = w[4*r+c][j];
  endtask

  // FIPS text order (first byte leftmost) to the block's packing (byte 0 at [7:0]).
  function automatic logic [127:0] bsw(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_a(input logic [127:0] k);
    exp_t e;
    expand(k);
    for (int r = 0; r <= 10; r++) begin
      e.rk = mdl[r]; e.idx = 4'(r); e.last = (r == 10);
      sb_a.push_back(e);
    end
  endtask

  // Monitors: a handshake completes at the next posedge when valid&&ready here.
  always @(negedge clk) begin
    if (rst_n && rk_valid && rk_ready) begin
      cap_a[rk_index]  = rk;
      last_a[rk_index] = rk_last;
      hs_a++;
      if (sb_a.size() == 0) fail("a_unexpected_rk");
      else begin
        ea = sb_a.pop_front();
        check("a_rk", rk, ea.rk);
        check("a_rk_index", 128'(rk_index), 128'(ea.idx));
        check("a_rk_last", 128'(rk_last), 128'(ea.last));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rv_b && rr_b) begin
      hs_b++;
      if (sb_b.size() == 0) fail("b_unexpected_rk");
      else begin
        eb = sb_b.pop_front();
        check("b_rk", rk_b, eb.rk);
        check("b_rk_index", 128'(ri_b), 128'(eb.idx));
        check("b_rk_last", 128'(rl_b), 128'(eb.last));
      end
    end
  end

  task automatic load_a(input logic [127:0] k);
    int n;
    n = 0;
    @(negedge clk);
    while (!key_ready && n < 100) begin @(negedge clk); n++; end
    if (!key_ready) fail("a_load_wait_key_ready");
    push_a(k);
    hs_a = 0;
    key = k;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key = rand128();
    check("a_latency1_valid", 128'(rk_valid), 128'(1'b1));
    check("a_round0_is_key", rk, k);
  endtask

  task automatic wait_done_a();
    int n;
    n = 0;
    @(negedge clk);
    while (!(rk_last && rk_ready) && n < 200) begin @(negedge clk); n++; end
    if (!(rk_last && rk_ready)) fail("a_wait_last");
    @(negedge clk);
    check("a_key_ready_after_last", 128'(key_ready), 128'(1'b1));
    check("a_valid_low_after_last", 128'(rk_valid), 128'(1'b0));
    check("a_key_count", 128'(hs_a), 128'(11));
  endtask

  task automatic wait_idx_a(input logic [3:0] idx);
    int n;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!(rk_valid && rk_index == idx) && n < 50);
    if (!(rk_valid && rk_index == idx)) fail("a_wait_index");
  endtask

  initial begin
    logic [127:0] k, k2, held;
    exp_t e;
    int n;
    key_valid = 1'b0; key = '0; rk_ready = 1'b1;
    kv_b = 1'b0; key_b = '0; rr_b = 1'b1;
    build_sbox();

    // Reset state
    #2;
    check("rst_rk_valid", 128'(rk_valid), 128'(1'b0));
    check("rst_rk", rk, 128'h0);
    check("rst_rk_index", 128'(rk_index), 128'(0));
    check("rst_rk_last", 128'(rk_last), 128'(1'b0));
    check("rst_b_rk_valid", 128'(rv_b), 128'(1'b0));
    #10 rst_n = 1'b1;
    #1 check("rst_key_ready", 128'(key_ready), 128'(1'b1));

    // FIPS-197 known answer
    k = bsw(128'h2b7e151628aed2a6abf7158809cf4f3c);
    load_a(k);
    wait_done_a();
    check("fips_round1", cap_a[1], bsw(128'ha0fafe1788542cb123a339392a6c7605));
    check("fips_round10", cap_a[10], bsw(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    check("fips_last10", 128'(last_a[10]), 128'(1'b1));

    // All-zero key, exercises the 1B/36 rcon steps
    load_a(128'h0);
    wait_done_a();
    check("zero_round1", cap_a[1], bsw(128'h62636363626363636263636362636363));
    check("zero_round10", cap_a[10], bsw(128'hb4ef5bcb3e92e21123e951cf6f8f188e));

    // Backpressure at round 4
    load_a(rand128());
    wait_idx_a(4'd4);
    rk_ready = 1'b0;
    held = rk;
    repeat (5) begin
      @(negedge clk);
      check("bp_rk_stable", rk, held);
      check("bp_index_stable", 128'(rk_index), 128'(4));
      check("bp_valid_stable", 128'(rk_valid), 128'(1'b1));
    end
    @(posedge clk); #1;
    rk_ready = 1'b1;
    wait_done_a();

    // Different key offered during RUN and held across the last handshake
    load_a(rand128());
    repeat (3) @(posedge clk);
    #1;
    k2 = rand128();
    push_a(k2);
    key = k2;
    key_valid = 1'b1;
    @(negedge clk);
    check("run_key_ready_low", 128'(key_ready), 128'(1'b0));
    n = 0;
    while (!key_ready && n < 100) begin @(negedge clk); n++; end
    check("hold_no_early_accept", 128'(hs_a), 128'(11));
    check("hold_idle_valid_low", 128'(rk_valid), 128'(1'b0));
    hs_a = 0;
    @(posedge clk); #1;
    key_valid = 1'b0;
    check("hold_accept_next", 128'(rk_valid), 128'(1'b1));
    check("hold_round0", rk, k2);
    wait_done_a();

    // Asynchronous reset mid-run at round 6
    load_a(rand128());
    wait_idx_a(4'd6);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 128'(rk_valid), 128'(1'b0));
    check("async_rst_rk", rk, 128'h0);
    check("async_rst_index", 128'(rk_index), 128'(0));
    sb_a.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("async_rst_key_ready", 128'(key_ready), 128'(1'b1));
    load_a(rand128());
    wait_done_a();

    // Random keys
    repeat (3) begin
      load_a(rand128());
      wait_done_a();
    end

    // NUM_ROUNDS = 2 build: 3 keys, last at index 2, back to idle
    @(negedge clk);
    check("b_key_ready_idle", 128'(kr_b), 128'(1'b1));
    k = rand128();
    expand(k);
    for (int r = 0; r <= 2; r++) begin
      e.rk = mdl[r]; e.idx = 4'(r); e.last = (r == 2);
      sb_b.push_back(e);
    end
    hs_b = 0;
    key_b = k;
    kv_b = 1'b1;
    @(posedge clk); #1;
    kv_b = 1'b0;
    check("b_latency1_valid", 128'(rv_b), 128'(1'b1));
    n = 0;
    @(negedge clk);
    while (!kr_b && n < 50) begin @(negedge clk); n++; end
    if (!kr_b) fail("b_wait_idle");
    check("b_key_count", 128'(hs_b), 128'(3));
    check("b_idle_valid_low", 128'(rv_b), 128'(1'b0));

    repeat (2) @(negedge clk);
    check("a_scoreboard_drained", 128'(sb_a.size()), 128'(0));
    check("b_scoreboard_drained", 128'(sb_b.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
